// File: rtl/dmem_store_buffer.sv
// Posting store buffer between MEM stage and a single-ported data memory: circular FIFO,
// one drain per cycle, youngest-match load forwarding, stall on full or pending fence.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [AW-1:0]          req_adr,
  input  logic [31:0]            req_wdata,
  input  logic                   fence,
  output logic [31:0]            rdata_m,
  output logic                   stall_m,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_adr,
  output logic [31:0]            mem_wd,
  input  logic [31:0]            mem_rd,
  input  logic                   mem_ready,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = AW - 2;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic [WW-1:0] adr_q [DEPTH];
  logic [31:0]   dat_q [DEPTH];

  logic          full;
  logic          is_load;
  logic          enq;
  logic          drain;
  logic          hit;
  logic          port_busy;
  logic [31:0]   fwd_dat;
  logic [PW-1:0] idx;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign stall_m = (req_valid & req_we & full) | (fence & ~empty);
  assign is_load = req_valid & ~req_we;
  assign enq     = req_valid & req_we & ~stall_m;

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    hit     = 1'b0;
    fwd_dat = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (adr_q[idx] == req_adr[AW-1:2])) begin
        hit     = 1'b1;
        fwd_dat = dat_q[idx];
      end
    end
  end

  // A load held off by a fence is not consumed, so it must not steal the port
  // from the drain that the fence is waiting on.
  assign port_busy = is_load & ~hit & ~stall_m;
  assign drain     = ~empty & mem_ready & ~port_busy;

  assign mem_we  = drain;
  assign mem_adr = drain ? {adr_q[head_q], 2'b00} : req_adr;
  assign mem_wd  = drain ? dat_q[head_q] : '0;
  assign rdata_m = (is_load & hit) ? fwd_dat : mem_rd;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + 1'b1;
    if (enq)   tail_d = tail_q + 1'b1;
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[tail_q] <= req_adr[AW-1:2];
      dat_q[tail_q] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, fence = 1'b0, mem_ready = 1'b0;
  logic [31:0] req_adr = '0, req_wdata = '0, mem_rd = '0;
  logic [31:0] rdata_m, mem_adr, mem_wd;
  logic        stall_m, mem_we, empty;
  logic [2:0]  count;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr), .req_wdata(req_wdata),
    .fence(fence), .rdata_m(rdata_m), .stall_m(stall_m),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [29:0] wa; logic [31:0] dat; } ent_t;
  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_enq, m_drain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input bit f, input bit rdy, input logic [31:0] rd);
    req_valid = v; req_we = we; req_adr = a; req_wdata = wd;
    fence = f; mem_ready = rdy; mem_rd = rd;
  endtask

  // Model: q is the buffer oldest-first; decide what must happen this cycle.
  task automatic settle_and_check();
    int n;
    bit exp_stall, load, hit, busy;
    logic [31:0] fwd;
    #1;
    n = q.size();
    exp_stall = (req_valid && req_we && n == DEPTH) || (fence && n != 0);
    m_enq = req_valid && req_we && !exp_stall;
    load  = req_valid && !req_we;
    hit = 1'b0; fwd = '0;
    for (int j = n - 1; j >= 0; j--)
      if (!hit && q[j].wa == req_adr[31:2]) begin hit = 1'b1; fwd = q[j].dat; end
    busy    = load && !hit && !exp_stall;
    m_drain = (n != 0) && mem_ready && !busy;
    chk("stall_m", stall_m, exp_stall);
    chk("mem_we", mem_we, m_drain);
    if (m_drain) begin
      chk("mem_adr", mem_adr, {q[0].wa, 2'b00});
      chk("mem_wd", mem_wd, q[0].dat);
    end else begin
      chk("mem_adr", mem_adr, req_adr);
    end
    if (load) chk("rdata_m", rdata_m, hit ? fwd : mem_rd);
    chk("count", count, n);
    chk("empty", empty, n == 0);
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_drain) void'(q.pop_front());
    if (m_enq)   q.push_back(ent_t'{req_adr[31:2], req_wdata});
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit rdy);
    drive(1, 1, a, d, 0, rdy, $urandom);
    settle_and_check();
    advance();
  endtask

  task automatic idle(input bit rdy);
    drive(0, 0, 32'h0, 32'h0, 0, rdy, $urandom);
    settle_and_check();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 0, 1, 32'h1234_5678);
    settle_and_check();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", stall_m, 0);
    chk("rst_rdata", rdata_m, 32'h1234_5678);
    reset = 1'b1;
    advance();

    // Post-and-drain
    drive(1, 1, 32'h10, 32'hAAAA_0001, 0, 1, 32'h0);
    settle_and_check();
    chk("pd_no_same_cycle_drain", mem_we, 0);
    advance();
    drive(0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    settle_and_check();
    chk("pd_count1", count, 1);
    chk("pd_we", mem_we, 1);
    chk("pd_adr", mem_adr, 32'h10);
    chk("pd_wd", mem_wd, 32'hAAAA_0001);
    advance();
    idle(0);
    chk("pd_count0", count, 0);

    // Forwarding, youngest wins
    store(32'h20, 32'h1, 0);
    store(32'h20, 32'h2, 0);
    drive(1, 0, 32'h22, 32'h0, 0, 0, 32'h5555_5555);
    settle_and_check();
    chk("fw_rdata", rdata_m, 32'h2);
    chk("fw_stall", stall_m, 0);
    chk("fw_we", mem_we, 0);
    advance();
    idle(1); idle(1);
    chk("fw_empty", empty, 1);

    // Full stall
    for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hB000_0000 + 32'(i), 0);
    drive(1, 1, 32'h30, 32'hB000_0030, 0, 0, 32'h0);
    settle_and_check();
    chk("full_count4", count, 4);
    chk("full_stall", stall_m, 1);
    advance();
    drive(1, 1, 32'h30, 32'hB000_0030, 0, 1, 32'h0);
    settle_and_check();
    chk("full_still4", count, 4);
    chk("full_stall_drain", stall_m, 1);
    chk("full_drain0", mem_adr, 32'h0);
    advance();
    drive(1, 1, 32'h30, 32'hB000_0030, 0, 1, 32'h0);
    settle_and_check();
    chk("full_unstall", stall_m, 0);
    chk("full_drain4", mem_adr, 32'h4);
    advance();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_a [3];
      exp_a[0] = 32'h8; exp_a[1] = 32'hC; exp_a[2] = 32'h30;
      drive(0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
      settle_and_check();
      chk("full_order", mem_adr, exp_a[i]);
      advance();
    end
    chk("full_empty", empty, 1);

    // Load-miss priority
    store(32'h40, 32'hC0, 0);
    store(32'h44, 32'hC4, 0);
    drive(1, 0, 32'h100, 32'h0, 0, 1, 32'hDEAD);
    settle_and_check();
    chk("lm_rdata", rdata_m, 32'hDEAD);
    chk("lm_adr", mem_adr, 32'h100);
    chk("lm_we", mem_we, 0);
    advance();
    drive(0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    settle_and_check();
    chk("lm_count", count, 2);
    chk("lm_resume", mem_we, 1);
    chk("lm_resume_adr", mem_adr, 32'h40);
    advance();
    idle(1);

    // Fence
    for (int i = 0; i < 3; i++) store(32'h60 + 32'(i * 4), 32'hF0 + 32'(i), 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
      settle_and_check();
      chk("fence_stall", stall_m, 1);
      advance();
    end
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    settle_and_check();
    chk("fence_release", stall_m, 0);
    chk("fence_empty", empty, 1);
    advance();
    drive(1, 1, 32'h70, 32'h77, 1, 1, 32'h0);
    settle_and_check();
    chk("fence_empty_nostall", stall_m, 0);
    advance();
    idle(1);

    // Reset mid-operation
    store(32'h50, 32'h5A, 0);
    store(32'h54, 32'h5B, 0);
    drive(0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_we", mem_we, 0);
    chk("mrst_empty", empty, 1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 32'h50, 32'h0, 0, 1, 32'hCAFE_F00D);
    settle_and_check();
    chk("mrst_load", rdata_m, 32'hCAFE_F00D);
    advance();

    // Wrap: 7 store/drain pairs walk the pointers past DEPTH
    for (int i = 0; i < 7; i++) begin
      store(32'h200 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1);
      idle(1);
    end
    drive(1, 0, 32'h204, 32'h0, 0, 1, 32'h0BAD_BEEF);
    settle_and_check();
    chk("wrap_empty", empty, 1);
    chk("wrap_miss", rdata_m, 32'h0BAD_BEEF);
    advance();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit v, we, f, rdy;
      logic [31:0] a;
      v   = ($urandom_range(0, 9) < 7);
      we  = $urandom_range(0, 1);
      f   = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      a   = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h100;
      drive(v, we, a, $urandom, f, rdy, $urandom);
      settle_and_check();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
